// File: rtl/iic_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : iic_cfg_pkg
// Brief    : Shared types, entry field offsets and ms-tick helper for the
//            I2C configuration sequencer. IIC_CFG_VERIFY_EN adds read states.
// Revision : 1.0 - initial release
// ============================================================================
package iic_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PWR_WAIT = 4'd1,
    ST_FETCH    = 4'd2,
    ST_DECODE   = 4'd3,
    ST_ISSUE    = 4'd4,
    ST_WAIT_HI  = 4'd5,
    ST_WAIT_LO  = 4'd6,
    ST_DELAY    = 4'd7,
    ST_NEXT     = 4'd8,
    ST_DONE     = 4'd9,
    ST_ERROR    = 4'd10
`ifdef IIC_CFG_VERIFY_EN
    ,
    ST_RD_ISSUE = 4'd11,
    ST_RD_HI    = 4'd12,
    ST_RD_LO    = 4'd13,
    ST_CHECK    = 4'd14
`endif
  } state_t;

  // Entry layout is {delay_flag, addr, data}; the flag sits above the address.
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int MS_W     = 16;

  function automatic int dly_bit(input int addr_byte);
    return addr_byte * 8 + 8;
  endfunction

  function automatic int ms_ticks(input int clk_fre);
    return (clk_fre / 1000 > 0) ? clk_fre / 1000 : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iic_cfg_ms_timer.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_ms_timer
// Brief    : Millisecond tick generator with a loadable ms down-counter;
//            expired_o is high while the remaining count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module iic_cfg_ms_timer
  import iic_cfg_pkg::*;
#(
  parameter int CLK_FRE  = 50_000_000,
  parameter int RESET_MS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [MS_W-1:0] load_ms_i,
  output logic            expired_o
);

  localparam int                TICKS     = ms_ticks(CLK_FRE);
  localparam int                TICK_W    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic              ms_tick;

  assign ms_tick   = (tick_q == TICK_LAST);
  assign expired_o = (ms_q == '0);

  always_comb begin
    tick_d = tick_q;
    ms_d   = ms_q;
    if (load_i) begin
      tick_d = '0;
      ms_d   = load_ms_i;
    end else if (!expired_o) begin
      if (ms_tick) begin
        tick_d = '0;
        ms_d   = ms_q - 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Reset preloads the power-up wait so it runs straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      ms_q   <= MS_W'(RESET_MS);
    end else begin
      tick_q <= tick_d;
      ms_q   <= ms_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iic_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_sequencer
// Brief    : Walks an external {delay, addr, data} table and issues one
//            single-byte I2C write per entry via the pulse/busy handshake.
//            Define IIC_CFG_VERIFY_EN for readback verify with retries.
// Revision : 1.0 - initial release
// ============================================================================
module iic_cfg_sequencer
  import iic_cfg_pkg::*;
#(
  parameter int         CLK_FRE      = 50_000_000,
  parameter logic [7:0] DEVICE_ID    = 8'h78,
  parameter int         ADDR_BYTE    = 1,
  parameter int         TABLE_LEN    = 64,
  parameter int         POWERUP_MS   = 20,
  parameter int         BUSY_TIMEOUT = 1024,
  parameter int         RETRY_MAX    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [7:0]             rom_addr,
  input  logic [ADDR_BYTE*8+8:0] rom_data,
  output logic                   iic_pluse,
  output logic                   iic_w_r,
  output logic [3:0]             iic_byte_len,
  output logic [7:0]             iic_device_id,
  output logic [ADDR_BYTE*8-1:0] iic_addr,
  output logic [7:0]             iic_data_in,
  input  logic                   iic_busy,
  input  logic [7:0]             iic_data_out,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [7:0]             err_idx
);

  localparam int              AW       = ADDR_BYTE * 8;
  localparam int              TO_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [7:0]      IDX_LAST = 8'(TABLE_LEN - 1);

  state_t          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            pluse_q, pluse_d;
  logic            wr_q, wr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      eidx_q, eidx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            tmr_load;
  logic [MS_W-1:0] tmr_ms;
  logic            tmr_expired;

`ifdef IIC_CFG_VERIFY_EN
  localparam int              RT_W   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(RETRY_MAX);
  logic [RT_W-1:0] retry_q, retry_d;
`else
  logic [39:0] unused_vfy;
  assign unused_vfy = {iic_data_out, 32'(RETRY_MAX)};
`endif

  iic_cfg_ms_timer #(
    .CLK_FRE  (CLK_FRE),
    .RESET_MS (POWERUP_MS)
  ) u_ms_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_ms_i (tmr_ms),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pluse_d  = pluse_q;
    wr_d     = wr_q;
    done_d   = done_q;
    err_d    = err_q;
    eidx_d   = eidx_q;
    to_d     = to_q;
    tmr_load = 1'b0;
    tmr_ms   = '0;
`ifdef IIC_CFG_VERIFY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      ST_IDLE:     state_d = ST_PWR_WAIT;
      ST_PWR_WAIT: begin
        if (tmr_expired) begin
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE: begin
        addr_d = rom_data[ADDR_LSB +: AW];
        data_d = rom_data[DATA_LSB +: 8];
`ifdef IIC_CFG_VERIFY_EN
        retry_d = '0;
`endif
        if (rom_data[dly_bit(ADDR_BYTE)]) begin
          tmr_load = 1'b1;
          tmr_ms   = MS_W'(rom_data[DATA_LSB +: 8]);
          state_d  = ST_DELAY;
        end else begin
          wr_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        pluse_d = 1'b1;
        to_d    = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (iic_busy) begin
          pluse_d = 1'b0;
          state_d = ST_WAIT_LO;
        end else if (to_q == TO_LAST) begin
          pluse_d = 1'b0;
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = ST_ERROR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!iic_busy) begin
`ifdef IIC_CFG_VERIFY_EN
          wr_d    = 1'b0;
          state_d = ST_RD_ISSUE;
`else
          state_d = ST_NEXT;
`endif
        end
      end
`ifdef IIC_CFG_VERIFY_EN
      ST_RD_ISSUE: begin
        pluse_d = 1'b1;
        to_d    = '0;
        state_d = ST_RD_HI;
      end
      ST_RD_HI: begin
        if (iic_busy) begin
          pluse_d = 1'b0;
          state_d = ST_RD_LO;
        end else if (to_q == TO_LAST) begin
          pluse_d = 1'b0;
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = ST_ERROR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_RD_LO:    if (!iic_busy) state_d = ST_CHECK;
      ST_CHECK: begin
        if (iic_data_out == data_q) begin
          state_d = ST_NEXT;
        end else if (retry_q == RT_MAX) begin
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = ST_ERROR;
        end else begin
          retry_d = retry_q + 1'b1;
          wr_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
`endif
      ST_DELAY:    if (tmr_expired) state_d = ST_NEXT;
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      // A re-run skips the power-up wait and restarts at entry 0.
      ST_DONE, ST_ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
`ifdef IIC_CFG_VERIFY_EN
          retry_d = '0;
`endif
          state_d = ST_FETCH;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PWR_WAIT;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pluse_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
      to_q    <= '0;
`ifdef IIC_CFG_VERIFY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pluse_q <= pluse_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
      to_q    <= to_d;
`ifdef IIC_CFG_VERIFY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign rom_addr      = idx_q;
  assign iic_pluse     = pluse_q;
  assign iic_w_r       = wr_q;
  assign iic_byte_len  = 4'd1;
  assign iic_device_id = DEVICE_ID;
  assign iic_addr      = addr_q;
  assign iic_data_in   = data_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign err_idx       = eidx_q;

endmodule
`default_nettype wire
